// File: rtl/spike_enc_pkg.sv
// spike_enc_pkg: shared timing constants and FSM state type for the spike encoder controller
package spike_enc_pkg;
  localparam int TIME_PERIOD     = 16;
  localparam int TESTING_PERIOD  = 8;
  localparam int LOG_TIME_PERIOD = 4;
  localparam int NUM_SPIKES      = 4;
  localparam int TW              = LOG_TIME_PERIOD + 1;
  localparam logic [TW-1:0] NULL_T = {1'b1, {LOG_TIME_PERIOD{1'b0}}};
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/pixel_encoder.sv
// pixel_encoder: maps one pixel intensity to a spike time; brighter pixels spike earlier
// ports: pixel (intensity in), spike_time (MSB set = no spike, else time step)
module pixel_encoder
  import spike_enc_pkg::*;
#(
  parameter int PIXW      = 8,
  parameter int ENC_SHIFT = 5,
  parameter int THRESH    = 32
) (
  input  logic [PIXW-1:0] pixel,
  output logic [TW-1:0]   spike_time
);
  localparam logic [PIXW-1:0] TMAX = PIXW'(TESTING_PERIOD - 1);
  logic [PIXW-1:0] t;
  logic [PIXW-1:0] tc;
  // ~pixel is (2^PIXW-1 - pixel)
  assign t  = ~pixel >> ENC_SHIFT;
  assign tc = (t > TMAX) ? TMAX : t;
  assign spike_time = (pixel < PIXW'(THRESH)) ? NULL_T : {1'b0, LOG_TIME_PERIOD'(tc)};
endmodule

// File: rtl/spike_encoder_ctrl.sv
// spike_encoder_ctrl: accepts pixel frames, encodes them to spike times and steps time through each frame
// ports: clk, rst_l (async active-low); in_valid/in_ready/in_pixels/in_training frame input;
//        time_val, spike_times, training, frame_start, frame_done, busy toward the layer
module spike_encoder_ctrl
  import spike_enc_pkg::*;
#(
  parameter int PIXW      = 8,
  parameter int ENC_SHIFT = 5,
  parameter int THRESH    = 32
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_SPIKES-1:0][PIXW-1:0] in_pixels,
  input  logic                            in_training,
  output logic [TW-1:0]                   time_val,
  output logic [NUM_SPIKES-1:0][TW-1:0]   spike_times,
  output logic                            training,
  output logic                            frame_start,
  output logic                            frame_done,
  output logic                            busy
);
  state_t state, state_n;
  logic [TW-1:0] time_n;
  logic [NUM_SPIKES-1:0][TW-1:0] enc;
  logic [NUM_SPIKES-1:0][TW-1:0] pend_times;
  logic pend_valid, pend_train;
  logic last, load, accept;
  for (genvar g = 0; g < NUM_SPIKES; g++) begin : g_enc
    pixel_encoder #(.PIXW(PIXW), .ENC_SHIFT(ENC_SHIFT), .THRESH(THRESH)) u_enc (
      .pixel(in_pixels[g]),
      .spike_time(enc[g])
    );
  end
  assign in_ready = !pend_valid;
  assign accept   = in_valid && !pend_valid;
  assign busy     = state == RUN;
  assign last     = busy && time_val == TW'((training ? TIME_PERIOD : TESTING_PERIOD) - 1);
  assign frame_start = busy && time_val == '0;
  assign frame_done  = last;
  // a pending frame starts either from IDLE or directly after the final step of the active one
  assign load = pend_valid && (state == IDLE || last);
  always_comb begin
    state_n = load ? RUN : (last ? IDLE : state);
    time_n  = load ? '0 : (busy && !last) ? time_val + 1'b1 : TW'(TIME_PERIOD - 1);
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= IDLE;
      time_val <= TW'(TIME_PERIOD - 1);
    end else begin
      state    <= state_n;
      time_val <= time_n;
    end
  end
  // pending buffer and active frame; load and accept are mutually exclusive through pend_valid
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend_valid  <= 1'b0;
      pend_train  <= 1'b0;
      pend_times  <= {NUM_SPIKES{NULL_T}};
      spike_times <= {NUM_SPIKES{NULL_T}};
      training    <= 1'b0;
    end else begin
      pend_valid <= accept || (pend_valid && !load);
      if (accept) begin
        pend_times <= enc;
        pend_train <= in_training;
      end
      if (load) begin
        spike_times <= pend_times;
        training    <= pend_train;
      end else if (last) begin
        spike_times <= {NUM_SPIKES{NULL_T}};
        training    <= 1'b0;
      end
    end
  end
endmodule
